// File: rtl/register_file_pkg.sv
// Shared constants for the ACC/ACCO/SP/RA special-purpose register file.
package register_file_pkg;

  localparam int RF_DATA_W = 16;
  localparam int NUM_REGS  = 4;

  localparam logic [1:0] DEST_ACC  = 2'd0;
  localparam logic [1:0] DEST_ACCO = 2'd1;
  localparam logic [1:0] DEST_SP   = 2'd2;
  localparam logic [1:0] DEST_RA   = 2'd3;

  localparam int RST_VAL = 0;

endpackage

// File: rtl/register_file_rf_reg.sv
// Single storage register: synchronous active-high clear, then optional load.
module rf_reg
  import register_file_pkg::*;
#(
  parameter int W = RF_DATA_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= W'(RST_VAL);
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/register_file.sv
// Four dedicated registers (ACC, ACCO, SP, RA), one write per clock, all always visible.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              write,
  input  logic [1:0]        Dest,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] ACC,
  output logic [DATA_W-1:0] ACCO,
  output logic [DATA_W-1:0] SP,
  output logic [DATA_W-1:0] RA
);

  logic [NUM_REGS-1:0] w_load;
  logic [DATA_W-1:0]   w_q [NUM_REGS];

  // One-hot load enables; reset priority is handled inside each register.
  always_comb begin
    w_load = '0;
    if (write) begin
      w_load[Dest] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    rf_reg #(
      .W(DATA_W)
    ) u_reg (
      .i_clk (CLK),
      .i_rst (rst),
      .i_load(w_load[g]),
      .i_d   (wrData),
      .o_q   (w_q[g])
    );
  end

  assign ACC  = w_q[DEST_ACC];
  assign ACCO = w_q[DEST_ACCO];
  assign SP   = w_q[DEST_SP];
  assign RA   = w_q[DEST_RA];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes expected register images, monitor compares.
module tb_register_file;

  logic        CLK = 1'b0;
  logic        rst;
  logic        write;
  logic [1:0]  Dest;
  logic [15:0] wrData;
  logic [15:0] ACC, ACCO, SP, RA;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] acco;
    logic [15:0] sp;
    logic [15:0] ra;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model[4];
  int          n_checks = 0;
  int          n_errors = 0;

  register_file #(.DATA_W(16)) dut (
    .CLK   (CLK),
    .rst   (rst),
    .write (write),
    .Dest  (Dest),
    .wrData(wrData),
    .ACC   (ACC),
    .ACCO  (ACCO),
    .SP    (SP),
    .RA    (RA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs wiggle with junk just after the falling edge, settle 2ns later;
  // only the settled values should be captured at the next rising edge.
  task automatic apply(input logic r, input logic w, input logic [1:0] d, input logic [15:0] data);
    exp_t e;
    @(negedge CLK);
    rst    = 1'($urandom);
    write  = 1'($urandom);
    Dest   = 2'($urandom);
    wrData = 16'($urandom);
    #2;
    rst    = r;
    write  = w;
    Dest   = d;
    wrData = data;
    if (r) begin
      for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    end else if (w) begin
      model[d] = data;
    end
    e.acc  = model[0];
    e.acco = model[1];
    e.sp   = model[2];
    e.ra   = model[3];
    exp_q.push_back(e);
  endtask

  // Monitor: checks just after the edge and again late in the cycle (after input wiggle).
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ACC",  ACC,  e.acc);
        chk("ACCO", ACCO, e.acco);
        chk("SP",   SP,   e.sp);
        chk("RA",   RA,   e.ra);
        #7;
        chk("ACC_stable",  ACC,  e.acc);
        chk("ACCO_stable", ACCO, e.acco);
        chk("SP_stable",   SP,   e.sp);
        chk("RA_stable",   RA,   e.ra);
      end
    end
  end

  initial begin
    logic r, w;
    int   waited;
    rst    = 1'b1;
    write  = 1'b0;
    Dest   = 2'd0;
    wrData = 16'h0000;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;

    apply(1'b1, 1'b1, 2'd3, 16'h5A5A);
    apply(1'b1, 1'b0, 2'd1, 16'hFFFF);
    apply(1'b0, 1'b1, 2'd0, 16'b1101001000100001);
    apply(1'b0, 1'b1, 2'd1, 16'h000F);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 2'd2, 16'h1C71);
    apply(1'b0, 1'b1, 2'd3, 16'hFF00);
    apply(1'b0, 1'b1, 2'd1, 16'h00FF);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 2'd1, 16'h00FF);
    apply(1'b0, 1'b1, 2'd2, 16'h8001);
    apply(1'b1, 1'b1, 2'd0, 16'hAAAA);
    apply(1'b0, 1'b1, 2'd2, 16'hFFFF);
    apply(1'b1, 1'b1, 2'd2, 16'h1234);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 15) == 0);
      w = 1'($urandom);
      apply(r, w, 2'($urandom), 16'($urandom));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      waited++;
    end
    repeat (2) @(posedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
